// File: rtl/ncl_bridge_pkg.sv
// rtl/ncl_bridge_pkg.sv - shared rail encodings, FSM states and dual-rail helper for the NCL adder bridge
package ncl_bridge_pkg;

  localparam logic [1:0] RAIL_NULL    = 2'b00;
  localparam logic [1:0] RAIL_DATA0   = 2'b01;
  localparam logic [1:0] RAIL_DATA1   = 2'b10;
  localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_WAIT_NULL
  } state_t;

  function automatic logic [1:0] enc_rail(input logic b);
    return b ? RAIL_DATA1 : RAIL_DATA0;
  endfunction

endpackage

// File: rtl/ncl_comp_sync.sv
// rtl/ncl_comp_sync.sv - DATA/NULL/illegal completion detect on N rail pairs plus a multi-flop synchronizer
module ncl_comp_sync
  import ncl_bridge_pkg::*;
#(
  parameter int N      = 9,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           init_n,
  input  logic [2*N-1:0] rails,
  output logic           data_sync,
  output logic           null_sync,
  output logic           illegal
);

  logic              data_raw;
  logic              null_raw;
  logic [STAGES-1:0] data_sh;
  logic [STAGES-1:0] null_sh;

  always_comb begin
    data_raw = 1'b1;
    null_raw = 1'b1;
    illegal  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rails[2*i+:2] == RAIL_NULL || rails[2*i+:2] == RAIL_ILLEGAL) data_raw = 1'b0;
      if (rails[2*i+:2] != RAIL_NULL) null_raw = 1'b0;
      if (rails[2*i+:2] == RAIL_ILLEGAL) illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      data_sh <= '0;
      null_sh <= '0;
    end else begin
      data_sh <= {data_sh[STAGES-2:0], data_raw};
      null_sh <= {null_sh[STAGES-2:0], null_raw};
    end
  end

  assign data_sync = data_sh[STAGES-1];
  assign null_sync = null_sh[STAGES-1];

endmodule

// File: rtl/ncl_sync_adder_bridge.sv
// rtl/ncl_sync_adder_bridge.sv - clocked source/sink wrapper around a W-bit NCL dual-rail ripple adder
module ncl_sync_adder_bridge
  import ncl_bridge_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic           clk,
  input  logic           init_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_sum,
  output logic           out_cout,
  output logic [2*W-1:0] a_dr,
  output logic [2*W-1:0] b_dr,
  output logic [1:0]     cin_dr,
  input  logic [W-1:0]   ab_comp,
  input  logic           cin_comp,
  input  logic [2*W-1:0] sum_dr,
  input  logic [1:0]     cout_dr,
  output logic [W-1:0]   sum_comp,
  output logic           cout_comp,
  output logic           err_illegal,
  output logic           err_timeout
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t         state;
  state_t         state_n;
  logic           accept;
  logic           capture;
  logic           rel;
  logic           take;
  logic           out_valid_n;
  logic           in_ready_n;
  logic           sum_data;
  logic           sum_null;
  logic           sum_ill;
  logic           comp_data;
  logic           comp_null;
  logic           comp_ill;
  logic [2*W+1:0] comp_rails;
  logic [2*W-1:0] a_enc;
  logic [2*W-1:0] b_enc;
  logic [W-1:0]   sum_bin;
  logic [TW-1:0]  timer;

  // Single-rail acks ride the DATA0 rail so the same detector yields all-1 / all-0.
  always_comb begin
    comp_rails = '0;
    a_enc      = '0;
    b_enc      = '0;
    sum_bin    = '0;
    for (int i = 0; i < W; i++) begin
      comp_rails[2*i] = ab_comp[i];
      a_enc[2*i+:2]   = enc_rail(in_a[i]);
      b_enc[2*i+:2]   = enc_rail(in_b[i]);
      sum_bin[i]      = sum_dr[2*i+1];
    end
    comp_rails[2*W] = cin_comp;
  end

  ncl_comp_sync #(.N(W + 1), .STAGES(SYNC_STAGES)) u_sum_sync (
    .clk       (clk),
    .init_n    (init_n),
    .rails     ({cout_dr, sum_dr}),
    .data_sync (sum_data),
    .null_sync (sum_null),
    .illegal   (sum_ill)
  );

  ncl_comp_sync #(.N(W + 1), .STAGES(SYNC_STAGES)) u_comp_sync (
    .clk       (clk),
    .init_n    (init_n),
    .rails     (comp_rails),
    .data_sync (comp_data),
    .null_sync (comp_null),
    .illegal   (comp_ill)
  );

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (accept)  state_n = ST_WAIT_DATA;
      ST_WAIT_DATA: if (capture) state_n = ST_WAIT_NULL;
      ST_WAIT_NULL: if (rel)     state_n = ST_IDLE;
      default:                   state_n = ST_IDLE;
    endcase
  end

  // A pending result blocks capture, which keeps COMP low and stalls the adder.
  always_comb begin
    accept      = (state == ST_IDLE) && in_ready && in_valid;
    capture     = (state == ST_WAIT_DATA) && sum_data && comp_data && !out_valid;
    rel         = (state == ST_WAIT_NULL) && sum_null && comp_null;
    take        = out_valid && out_ready;
    out_valid_n = capture || (out_valid && !take);
    in_ready_n  = (state_n == ST_IDLE) && !out_valid_n;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_cout    <= 1'b0;
      a_dr        <= '0;
      b_dr        <= '0;
      cin_dr      <= RAIL_NULL;
      sum_comp    <= '0;
      cout_comp   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      if (accept) begin
        a_dr   <= a_enc;
        b_dr   <= b_enc;
        cin_dr <= enc_rail(in_cin);
      end
      if (capture) begin
        out_sum   <= sum_bin;
        out_cout  <= cout_dr[1];
        a_dr      <= '0;
        b_dr      <= '0;
        cin_dr    <= RAIL_NULL;
        sum_comp  <= '1;
        cout_comp <= 1'b1;
      end
      if (rel) begin
        sum_comp  <= '0;
        cout_comp <= 1'b0;
      end
      if (sum_ill || comp_ill) err_illegal <= 1'b1;
    end
  end

  // Timer restarts on every state change and saturates at TIMEOUT while waiting.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      timer       <= '0;
      err_timeout <= 1'b0;
    end else if (state_n != state) begin
      timer <= '0;
    end else if (state != ST_IDLE && TIMEOUT != 0) begin
      if (timer == TW'(TIMEOUT)) err_timeout <= 1'b1;
      else                       timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_ncl_sync_adder_bridge.sv
// tb/tb_ncl_sync_adder_bridge.sv - self-checking bench with a behavioural NCL adder model
module tb_ncl_sync_adder_bridge;

  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int TO  = 16;
  localparam int DLY = 3;

  logic           clk = 1'b0;
  logic           init_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_cin = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_sum;
  logic           out_cout;
  logic [2*W-1:0] a_dr;
  logic [2*W-1:0] b_dr;
  logic [1:0]     cin_dr;
  logic [W-1:0]   ab_comp = '0;
  logic           cin_comp = 1'b0;
  logic [2*W-1:0] sum_dr = '0;
  logic [1:0]     cout_dr = '0;
  logic [W-1:0]   sum_comp;
  logic           cout_comp;
  logic           err_illegal;
  logic           err_timeout;

  always #5 clk = ~clk;

  ncl_sync_adder_bridge #(.W(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk(clk), .init_n(init_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .a_dr(a_dr), .b_dr(b_dr), .cin_dr(cin_dr),
    .ab_comp(ab_comp), .cin_comp(cin_comp), .sum_dr(sum_dr), .cout_dr(cout_dr),
    .sum_comp(sum_comp), .cout_comp(cout_comp),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] enc_vec(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i+:2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [W-1:0] dec_vec(input logic [2*W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[2*i+1];
    return r;
  endfunction

  function automatic bit all_data(input logic [2*W+1:0] v);
    for (int i = 0; i <= W; i++) if (v[2*i] == v[2*i+1]) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural NCL adder: DLY cycles after a complete wavefront it emits the
  // matching output wavefront and raises its input acknowledges.
  int         m_phase = 0;
  int         m_cnt = 0;
  logic [W:0] m_res = '0;
  logic       hold_comp = 1'b0;
  logic       force_ill = 1'b0;

  always @(negedge clk) begin
    if (!init_n) begin
      m_phase = 0;
      m_cnt   = 0;
    end else if (m_phase == 0) begin
      if (all_data({cin_dr, b_dr, a_dr}) && sum_comp == '0 && !cout_comp) begin
        m_cnt++;
        if (m_cnt >= DLY) begin
          m_phase = 1;
          m_cnt   = 0;
          m_res   = (W+1)'(dec_vec(a_dr)) + (W+1)'(dec_vec(b_dr)) + (W+1)'(cin_dr[1]);
        end
      end else m_cnt = 0;
    end else begin
      if ({cin_dr, b_dr, a_dr} == '0 && sum_comp == '1 && cout_comp) begin
        m_cnt++;
        if (m_cnt >= DLY) begin
          m_phase = 0;
          m_cnt   = 0;
        end
      end else m_cnt = 0;
    end
    sum_dr   = (m_phase == 1) ? enc_vec(m_res[W-1:0]) : '0;
    cout_dr  = (m_phase == 1) ? (m_res[W] ? 2'b10 : 2'b01) : 2'b00;
    ab_comp  = (m_phase == 1 && !hold_comp) ? '1 : '0;
    cin_comp = (m_phase == 1);
    if (force_ill) begin
      sum_dr[7:6] = 2'b11;
      force_ill   = 1'b0;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic take_result();
    int k = 0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_cleared", out_valid, 0);
    while (sum_comp != '0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("sum_comp_back_to_0", {sum_comp, cout_comp}, 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input bit take_it);
    int k = 0;
    wait_ready();
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    @(negedge clk);
    in_valid = 1'b0;
    check("a_dr_data", a_dr, enc_vec(a));
    check("b_dr_data", b_dr, enc_vec(b));
    check("cin_dr_data", cin_dr, c ? 2'b10 : 2'b01);
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("out_valid_set", out_valid, 1);
    check("out_sum", out_sum, es);
    check("out_cout", out_cout, ec);
    check("sum_comp_all1", {sum_comp, cout_comp}, 9'h1FF);
    check("inputs_null", {a_dr, b_dr, cin_dr}, 0);
    if (take_it) take_result();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rexp;
    int           rdy_cnt;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
    tbl[2] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rails", {a_dr, b_dr, cin_dr}, 0);
    check("rst_comp", {sum_comp, cout_comp}, 0);
    check("rst_out_data", {out_sum, out_cout}, 0);
    check("rst_errors", {err_illegal, err_timeout}, 0);
    init_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra   = W'($urandom_range(0, 255));
      rb   = W'($urandom_range(0, 255));
      rc   = 1'($urandom_range(0, 1));
      rexp = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
      run_op(ra, rb, rc, rexp[W-1:0], rexp[W], 1'b1);
    end
    check("no_timeout_normal", err_timeout, 0);
    check("no_illegal_normal", err_illegal, 0);

    // Backpressure: result not taken, second operand must wait.
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_cin = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) rdy_cnt++;
    end
    in_valid = 1'b0;
    check("bp_no_ready", rdy_cnt, 0);
    check("bp_out_valid_held", out_valid, 1);
    check("bp_out_sum_held", out_sum, 8'h46);
    check("bp_comp_returned", {sum_comp, cout_comp}, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_clear_and_ready", {out_valid, in_ready}, 2'b01);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);

    // Illegal rail pair while idle.
    force_ill = 1'b1;
    repeat (2) @(negedge clk);
    check("err_illegal_set", err_illegal, 1);
    run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b1);
    check("err_illegal_sticky", err_illegal, 1);

    // Adder never acknowledges its inputs.
    hold_comp = 1'b1;
    wait_ready();
    in_valid = 1'b1; in_a = 8'h21; in_b = 8'h10; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("timeout_not_yet", err_timeout, 0);
    repeat (30) @(negedge clk);
    check("timeout_set", err_timeout, 1);
    check("timeout_still_waiting", {out_valid, in_ready}, 0);
    check("timeout_inputs_data", a_dr, enc_vec(8'h21));
    init_n = 1'b0;
    hold_comp = 1'b0;
    repeat (3) @(negedge clk);
    init_n = 1'b1;
    repeat (2) @(negedge clk);
    check("errors_cleared_by_reset", {err_illegal, err_timeout}, 0);

    // Reset while the bridge waits for the NULL wavefront.
    run_op(8'h09, 8'h09, 1'b0, 8'h12, 1'b0, 1'b0);
    init_n = 1'b0;
    #1;
    check("async_rst_rails", {a_dr, b_dr, cin_dr}, 0);
    check("async_rst_comp", {sum_comp, cout_comp}, 0);
    check("async_rst_valid_ready", {out_valid, in_ready}, 0);
    repeat (3) @(negedge clk);
    init_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_release_ready", in_ready, 1);
    run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ncl_sync_adder_bridge.md
Name: ncl_sync_adder_bridge

Overview:
Clocked boundary stage between synchronous logic and a W-bit NCL dual-rail ripple adder built from full-adder stages. Upstream, it encodes binary operands into dual-rail DATA/NULL wavefronts on A, B and carry-in, and obeys the adder's completion acknowledges. Downstream, it consumes dual-rail sum and carry-out, acknowledges them via COMP signals, and returns a registered binary result on a valid/ready handshake. It is the source and sink that a chain of these adders needs in a mixed clocked/NCL datapath.

Parameters:
W, 8, adder width in bits (one full-adder stage per bit)
SYNC_STAGES, 2, flops per synchronizer on NCL-side inputs (min 2)
TIMEOUT, 1023, cycles allowed per wait state before timeout flag; 0 disables

Ports:
clk  in  1  clock
init_n  in  1  async active-low reset
in_valid  in  1  operand valid
in_ready  out  1  operand accept
in_a  in  W  operand A
in_b  in  W  operand B
in_cin  in  1  carry in
out_valid  out  1  result valid
out_ready  in  1  result accept
out_sum  out  W  binary sum
out_cout  out  1  binary carry out
a_dr  out  2W  dual-rail A; bit i on [2i+1:2i]
b_dr  out  2W  dual-rail B
cin_dr  out  2  dual-rail carry-in to stage 0
ab_comp  in  W  per-stage input acknowledge (async)
cin_comp  in  1  stage-0 carry-in acknowledge (async)
sum_dr  in  2W  dual-rail sum (async)
cout_dr  in  2  dual-rail carry out of stage W-1 (async)
sum_comp  out  W  per-bit sum acknowledge to adder
cout_comp  out  1  carry-out acknowledge to adder
err_illegal  out  1  sticky: both rails high seen on sum_dr/cout_dr
err_timeout  out  1  sticky: a wait exceeded TIMEOUT

Behaviour:
- Encoding: 2'b00 NULL, 2'b01 DATA0, 2'b10 DATA1, 2'b11 illegal. COMP=1 means "DATA received, send NULL"; COMP=0 means "ready for DATA".
- Reset (init_n=0, async): a_dr/b_dr/cin_dr = 0 (NULL), sum_comp/cout_comp = 0, in_ready=0, out_valid=0, out_sum/out_cout=0, errors=0, FSM=IDLE, timer=0.
- The adder inputs are registered. ab_comp, cin_comp and the completion flags are synchronized through SYNC_STAGES flops. Sum is captured only after the synchronized DATA-complete flag is seen. NCL holds DATA until COMP rises, so the capture is stable.
- DATA-complete: every pair of sum_dr and cout_dr has exactly one rail high. NULL-complete: all rails low. Both are computed combinationally, then synchronized.
- FSM:
  - IDLE: in_ready = !out_valid. On in_valid&&in_ready, register the encoding of in_a/in_b/in_cin onto the dual-rail outputs (next cycle) and go to WAIT_DATA.
  - WAIT_DATA: wait for all three conditions: synced DATA-complete, synced ab_comp all 1, synced cin_comp=1. Once they hold and out_valid=0, capture out_sum/out_cout, set out_valid, drive sum_comp=all 1 and cout_comp=1, and drive all inputs NULL, then go to WAIT_NULL. If out_valid=1 (result not yet taken), stall with COMP held at 0 (backpressure into NCL).
  - WAIT_NULL: wait for all three conditions: synced NULL-complete, synced ab_comp all 0, synced cin_comp=0. Then set sum_comp=0 and cout_comp=0, and go to IDLE.
- Output handshake: out_valid clears on out_valid&&out_ready. in_ready may assert in the same cycle as that clear.
- Latency: in accept to out_valid ≥ SYNC_STAGES+2 cycles plus NCL settle. Throughput is one operation per full DATA/NULL cycle.
- Illegal rail pair (unsynchronized sample, any state): set err_illegal; sticky until reset; the FSM continues.
- Timer: resets on every state entry and counts while in a WAIT state. When it reaches TIMEOUT (nonzero), err_timeout is set (sticky), the timer saturates, and the FSM keeps waiting.
- Reset mid-operation returns the block to the reset values immediately. The NCL side is expected to be initialised by the same reset domain.

Decomposition:
- Package ncl_bridge_pkg:
  - rail constants NULL/DATA0/DATA1/ILLEGAL
  - FSM state enum {IDLE, WAIT_DATA, WAIT_NULL}
  - function encoding a bit to dual-rail
- Sub-module ncl_comp_sync:
  - parameterised width and stage count
  - completion detect (DATA/NULL/illegal) plus the SYNC_STAGES synchronizer
  - instantiated once for sum_dr/cout_dr and once for ab_comp/cin_comp

Test Plan:
- W=8, in_a=8'h0F, in_b=8'h01, in_cin=0, behavioural NCL adder model with 3-cycle delay -> out_sum=8'h10, out_cout=0; a_dr bit0 = 2'b10 while DATA, then all 0 at NULL.
- in_a=8'hFF, in_b=8'h01, in_cin=1 -> out_sum=8'h01, out_cout=1; sum_comp goes 8'hFF then 8'h00 in order.
- out_ready held 0 after the first result, second operand accepted? -> in_ready=0, no second accept; once ready, second DATA completes but sum_comp stays 0 until out_ready pulses.
- Model forces sum_dr pair 3 to 2'b11 for one cycle -> err_illegal=1 and remains 1 until init_n low.
- Model never returns ab_comp, TIMEOUT=16 -> err_timeout=1 after 16 cycles in WAIT_DATA; FSM still in WAIT_DATA.
- init_n asserted low during WAIT_NULL -> all dual-rail and COMP outputs 0, out_valid=0 asynchronously; after release, in_ready=1 and a fresh op 3+4 yields 7.
